// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_port_arbiter_pkg                                                    |
// | Shared types, size encodings and load-extension helper for the arbiter.|
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
package mem_port_arbiter_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;
  typedef enum logic [0:0] {FETCH = 1'b0, DATA = 1'b1} req_id_t;

  localparam logic [1:0] c_size_byte  = 2'b01;
  localparam logic [1:0] c_size_word  = 2'b10;
  localparam logic [1:0] c_size_dword = 2'b11;

  localparam int c_default_timeout = 15;

  function automatic logic [63:0] load_extend(input logic [1:0] size, input logic [63:0] raw);
    case (size)
      c_size_byte: load_extend = {56'd0, raw[7:0]};
      c_size_word: load_extend = {32'd0, raw[31:0]};
      default:     load_extend = raw;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arb2.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rr_arb2                                                                 |
// | Two-requester round-robin arbiter with per-requester masks.            |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic    clock,
  input  logic    reset_n,
  input  logic    req_fetch,
  input  logic    req_data,
  input  logic    mask_fetch,
  input  logic    mask_data,
  input  logic    accept,
  output logic    gnt_valid,
  output req_id_t gnt_id
);

  req_id_t r_last_grant;
  logic    w_elig_fetch;
  logic    w_elig_data;

  assign w_elig_fetch = req_fetch & ~mask_fetch;
  assign w_elig_data  = req_data  & ~mask_data;

  always_comb begin
    gnt_valid = w_elig_fetch | w_elig_data;
    gnt_id    = FETCH;
    if (w_elig_fetch && w_elig_data)
      gnt_id = (r_last_grant == FETCH) ? DATA : FETCH;
    else if (w_elig_data)
      gnt_id = DATA;
  end

  // Resetting to FETCH lets the data port win the very first tie.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_last_grant <= FETCH;
    else if (accept && gnt_valid)
      r_last_grant <= gnt_id;
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_port_arbiter                                                        |
// | Shares one memory port between a fetch and a data requester.           |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = c_default_timeout,
  parameter int AW      = 64
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [31:0]   f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [63:0]   d_wdata,
  output logic          d_ack,
  output logic [63:0]   d_rdata,
  output logic          m_cs,
  output logic          m_we,
  output logic [1:0]    m_size,
  output logic [AW-1:0] m_addr,
  output logic [63:0]   m_wdata,
  input  logic [63:0]   m_rdata,
  input  logic          m_ready,
  output logic          busy,
  output logic          bus_err
);

  localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

  state_t               r_state;
  req_id_t              r_id;
  logic                 r_we;
  logic [1:0]           r_size;
  logic [AW-1:0]        r_addr;
  logic [63:0]          r_wdata;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 w_gnt_valid;
  req_id_t              w_gnt_id;
  logic                 w_done;

  rr_arb2 u_arb (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_fetch  (f_req),
    .req_data   (d_req),
    .mask_fetch (f_ack),
    .mask_data  (d_ack),
    .accept     (r_state == IDLE),
    .gnt_valid  (w_gnt_valid),
    .gnt_id     (w_gnt_id)
  );

  assign w_done  = m_ready || (r_cnt == c_cnt_last);
  assign busy    = (r_state == ACCESS);
  assign m_cs    = busy;
  // Latched fields are cleared on exit so the bus reads zero while idle.
  assign m_we    = r_we;
  assign m_size  = r_size;
  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_id    <= FETCH;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      f_ack   <= 1'b0;
      d_ack   <= 1'b0;
      bus_err <= 1'b0;
      f_rdata <= '0;
      d_rdata <= '0;
    end else begin
      f_ack   <= 1'b0;
      d_ack   <= 1'b0;
      bus_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_state <= ACCESS;
            r_id    <= w_gnt_id;
            r_cnt   <= '0;
            if (w_gnt_id == DATA) begin
              r_addr  <= d_addr;
              r_we    <= d_we;
              r_size  <= d_size;
              r_wdata <= d_wdata;
            end else begin
              r_addr  <= f_addr;
              r_we    <= 1'b0;
              r_size  <= c_size_word;
              r_wdata <= '0;
            end
          end
        end
        ACCESS: begin
          if (w_done) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= '0;
            r_wdata <= '0;
            bus_err <= ~m_ready;
            if (r_id == FETCH) begin
              f_ack   <= 1'b1;
              f_rdata <= m_ready ? m_rdata[31:0] : 32'd0;
            end else begin
              d_ack <= 1'b1;
              if (!r_we)
                d_rdata <= m_ready ? load_extend(r_size, m_rdata) : 64'd0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                     |
// | Scenario tasks plus a randomized transaction-level reference model.    |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  localparam int AW = 64;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic          f_ack;
  logic [31:0]   f_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [1:0]    d_size = 2'b00;
  logic [AW-1:0] d_addr = '0;
  logic [63:0]   d_wdata = '0;
  logic          d_ack;
  logic [63:0]   d_rdata;
  logic          m_cs;
  logic          m_we;
  logic [1:0]    m_size;
  logic [AW-1:0] m_addr;
  logic [63:0]   m_wdata;
  logic [63:0]   m_rdata = '0;
  logic          m_ready = 1'b0;
  logic          busy;
  logic          bus_err;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(.TIMEOUT(15), .AW(AW)) dut (
    .clock(clock), .reset_n(reset_n),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .m_cs(m_cs), .m_we(m_we), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready),
    .busy(busy), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    f_req = 0; d_req = 0; m_ready = 0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    f_req = 1; d_req = 1; m_ready = 1; m_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    step();
    n_cmp++;
    if ({f_ack, d_ack, bus_err, busy, m_cs, m_we, m_size} !== 8'd0 || m_addr !== '0 ||
        m_wdata !== '0 || f_rdata !== '0 || d_rdata !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got ack=%b%b err=%b busy=%b cs=%b addr=%h frd=%h drd=%h, need all zero",
               f_ack, d_ack, bus_err, busy, m_cs, m_addr, f_rdata, d_rdata);
    end
    f_req = 0; d_req = 0; m_ready = 0; m_rdata = '0;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_fetch();
    f_req = 1; f_addr = 64'h100;
    step();
    f_req = 0;
    n_cmp++;
    if (m_cs !== 1'b1 || m_size !== 2'b10 || m_addr !== 64'h100 || m_we !== 1'b0 || m_wdata !== '0) begin
      n_bad++;
      $display("FAIL fetch_grant: got cs=%b size=%b addr=%h we=%b, need cs=1 size=10 addr=100 we=0",
               m_cs, m_size, m_addr, m_we);
    end
    step();
    step();
    m_ready = 1; m_rdata = 64'hDEADBEEF_8B020020;
    step();
    m_ready = 0;
    n_cmp++;
    if (f_ack !== 1'b1 || f_rdata !== 32'h8B020020 || m_cs !== 1'b0 || bus_err !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_done: got ack=%b rdata=%h cs=%b err=%b, need ack=1 rdata=8b020020 cs=0 err=0",
               f_ack, f_rdata, m_cs, bus_err);
    end
    step();
    n_cmp++;
    if (f_ack !== 1'b0 || f_rdata !== 32'h8B020020) begin
      n_bad++;
      $display("FAIL fetch_hold: got ack=%b rdata=%h, need ack=0 rdata=8b020020", f_ack, f_rdata);
    end
  endtask

  task automatic test_tie();
    do_reset();
    f_req = 1; d_req = 1; d_we = 0; d_size = 2'b11;
    f_addr = 64'hAAAA_0000; d_addr = 64'hBBBB_0000;
    step();
    n_cmp++;
    if (m_cs !== 1'b1 || m_addr !== 64'hBBBB_0000 || m_size !== 2'b11) begin
      n_bad++;
      $display("FAIL tie_first: got cs=%b addr=%h size=%b, need cs=1 addr=bbbb0000 size=11", m_cs, m_addr, m_size);
    end
    m_ready = 1;
    step();
    m_ready = 0;
    n_cmp++;
    if (d_ack !== 1'b1 || m_cs !== 1'b0) begin
      n_bad++;
      $display("FAIL tie_data_ack: got d_ack=%b cs=%b, need d_ack=1 cs=0", d_ack, m_cs);
    end
    step();
    n_cmp++;
    if (m_cs !== 1'b1 || m_addr !== 64'hAAAA_0000 || m_size !== 2'b10 || d_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL tie_second: got cs=%b addr=%h size=%b d_ack=%b, need cs=1 addr=aaaa0000 size=10 d_ack=0",
               m_cs, m_addr, m_size, d_ack);
    end
    f_req = 0; d_req = 0; m_ready = 1;
    step();
    m_ready = 0;
    n_cmp++;
    if (f_ack !== 1'b1 || d_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL tie_fetch_ack: got f_ack=%b d_ack=%b, need f_ack=1 d_ack=0", f_ack, d_ack);
    end
    step();
  endtask

  task automatic test_byte();
    d_req = 1; d_we = 0; d_size = 2'b01; d_addr = 64'h4003;
    step();
    d_req = 0;
    n_cmp++;
    if (m_size !== 2'b01 || m_we !== 1'b0 || m_addr !== 64'h4003) begin
      n_bad++;
      $display("FAIL byte_load_bus: got size=%b we=%b addr=%h, need size=01 we=0 addr=4003", m_size, m_we, m_addr);
    end
    m_ready = 1; m_rdata = 64'h1122334455667788;
    step();
    m_ready = 0;
    n_cmp++;
    if (d_ack !== 1'b1 || d_rdata !== 64'h88) begin
      n_bad++;
      $display("FAIL byte_load_data: got ack=%b rdata=%h, need ack=1 rdata=88", d_ack, d_rdata);
    end
    step();
    d_req = 1; d_we = 1; d_size = 2'b01; d_wdata = 64'hAB;
    step();
    d_req = 0; d_wdata = 64'hFF; d_we = 0; d_size = 2'b11;
    step();
    n_cmp++;
    if (m_cs !== 1'b1 || m_we !== 1'b1 || m_size !== 2'b01 || m_wdata !== 64'hAB) begin
      n_bad++;
      $display("FAIL byte_store_bus: got cs=%b we=%b size=%b wdata=%h, need cs=1 we=1 size=01 wdata=ab",
               m_cs, m_we, m_size, m_wdata);
    end
    m_ready = 1; m_rdata = 64'h5555_6666_7777_9999;
    step();
    m_ready = 0;
    n_cmp++;
    if (d_ack !== 1'b1 || d_rdata !== 64'h88) begin
      n_bad++;
      $display("FAIL byte_store_rdata: got ack=%b rdata=%h, need ack=1 rdata=88", d_ack, d_rdata);
    end
    step();
  endtask

  task automatic test_timeout();
    int cycles;
    d_req = 1; d_we = 0; d_size = 2'b11; m_ready = 0;
    step();
    d_req = 0;
    cycles = 0;
    while (m_cs && cycles < 40) begin
      cycles++;
      step();
    end
    n_cmp++;
    if (cycles != 15 || bus_err !== 1'b1 || d_ack !== 1'b1 || d_rdata !== 64'd0) begin
      n_bad++;
      $display("FAIL timeout_err: got cycles=%0d err=%b ack=%b rdata=%h, need cycles=15 err=1 ack=1 rdata=0",
               cycles, bus_err, d_ack, d_rdata);
    end
    step();
    n_cmp++;
    if (bus_err !== 1'b0 || d_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_pulse: got err=%b ack=%b, need err=0 ack=0", bus_err, d_ack);
    end
    d_req = 1; m_rdata = 64'h0123_4567_89AB_CDEF;
    step();
    d_req = 0;
    cycles = 0;
    while (m_cs && cycles < 40) begin
      cycles++;
      m_ready = (cycles == 15);
      step();
    end
    m_ready = 0;
    n_cmp++;
    if (cycles != 15 || bus_err !== 1'b0 || d_ack !== 1'b1 || d_rdata !== 64'h0123_4567_89AB_CDEF) begin
      n_bad++;
      $display("FAIL timeout_edge_ready: got cycles=%0d err=%b ack=%b rdata=%h, need cycles=15 err=0 ack=1 rdata=0123456789abcdef",
               cycles, bus_err, d_ack, d_rdata);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int stray;
    d_req = 1; d_we = 0; d_size = 2'b11; d_addr = 64'hD000;
    step();
    d_req = 0;
    step();
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (m_cs !== 1'b0 || busy !== 1'b0 || d_rdata !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_async: got cs=%b busy=%b rdata=%h, need cs=0 busy=0 rdata=0", m_cs, busy, d_rdata);
    end
    step();
    reset_n = 1'b1; m_ready = 1;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (f_ack || d_ack || bus_err || m_cs) stray++;
    end
    m_ready = 0;
    n_cmp++;
    if (stray != 0) begin
      n_bad++;
      $display("FAIL reset_no_ack: got %0d stray cycles, need 0", stray);
    end
    f_req = 1; d_req = 1; f_addr = 64'hF000; d_addr = 64'hD000;
    step();
    f_req = 0; d_req = 0;
    n_cmp++;
    if (m_cs !== 1'b1 || m_addr !== 64'hD000) begin
      n_bad++;
      $display("FAIL reset_tie_data: got cs=%b addr=%h, need cs=1 addr=d000", m_cs, m_addr);
    end
    m_ready = 1;
    step();
    m_ready = 0;
    step();
  endtask

  task automatic test_req_drop();
    int acks;
    d_req = 1; d_we = 0; d_size = 2'b11;
    step();
    d_req = 0;
    step();
    step();
    m_ready = 1; m_rdata = 64'h7;
    step();
    m_ready = 0;
    acks = int'(d_ack);
    for (int i = 0; i < 4; i++) begin
      step();
      acks += int'(d_ack);
    end
    n_cmp++;
    if (acks != 1 || d_rdata !== 64'h7) begin
      n_bad++;
      $display("FAIL req_drop: got acks=%0d rdata=%h, need acks=1 rdata=7", acks, d_rdata);
    end
  endtask

  // Transaction-level model: who wins, what goes on the bus, how long, and what lands in rdata.
  task automatic test_random();
    bit         last_data;
    bit         fq, dq, win, dwe, to;
    logic [1:0] dsz;
    logic [63:0] fa, da, dwd, rd, exp_d;
    logic [31:0] exp_f;
    int         lat, cycles, exp_cycles, pick;
    do_reset();
    last_data = 0; exp_f = '0; exp_d = '0;
    for (int it = 0; it < 40; it++) begin
      pick = int'($urandom_range(1, 3));
      fq = pick[0]; dq = pick[1];
      fa = {$urandom, $urandom}; da = {$urandom, $urandom}; dwd = {$urandom, $urandom};
      dwe = 1'($urandom_range(0, 1));
      dsz = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b11;
      lat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(13, 18)) : int'($urandom_range(0, 4));
      f_req = fq; f_addr = fa; d_req = dq; d_addr = da; d_we = dwe; d_size = dsz; d_wdata = dwd;
      step();
      win = (fq && dq) ? ~last_data : dq;
      last_data = win;
      n_cmp++;
      if (m_cs !== 1'b1 || m_addr !== (win ? da : fa) || m_we !== (win ? dwe : 1'b0) ||
          m_size !== (win ? dsz : 2'b10) || m_wdata !== (win ? dwd : 64'd0)) begin
        n_bad++;
        $display("FAIL rand_grant[%0d]: got cs=%b addr=%h we=%b size=%b wdata=%h, need winner=%0d",
                 it, m_cs, m_addr, m_we, m_size, m_wdata, win);
      end
      f_req = 0; d_req = 0; f_addr = {$urandom, $urandom}; d_addr = {$urandom, $urandom};
      rd = {$urandom, $urandom}; m_rdata = rd;
      cycles = 0;
      while (m_cs && cycles < 40) begin
        cycles++;
        m_ready = (cycles == lat + 1);
        step();
      end
      m_ready = 0;
      to = (lat >= 15);
      exp_cycles = to ? 15 : lat + 1;
      if (!win) exp_f = to ? 32'd0 : rd[31:0];
      else if (!dwe) exp_d = to ? 64'd0 : ((dsz == 2'b01) ? {56'd0, rd[7:0]} : rd);
      n_cmp++;
      if (cycles != exp_cycles || f_ack !== ~win || d_ack !== win || bus_err !== to ||
          f_rdata !== exp_f || d_rdata !== exp_d) begin
        n_bad++;
        $display("FAIL rand_done[%0d]: got cyc=%0d ack=%b%b err=%b frd=%h drd=%h, need cyc=%0d ack=%b%b err=%b frd=%h drd=%h",
                 it, cycles, f_ack, d_ack, bus_err, f_rdata, d_rdata, exp_cycles, ~win, win, to, exp_f, exp_d);
      end
      m_ready = 1'($urandom_range(0, 1));
      step();
      m_ready = 0;
      n_cmp++;
      if (f_ack !== 1'b0 || d_ack !== 1'b0 || bus_err !== 1'b0 || m_cs !== 1'b0) begin
        n_bad++;
        $display("FAIL rand_idle[%0d]: got ack=%b%b err=%b cs=%b, need all 0", it, f_ack, d_ack, bus_err, m_cs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_tie();
    test_byte();
    test_timeout();
    test_reset_mid();
    test_req_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
